// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: 2-read/1-write register file with a per-register busy
// scoreboard and pending-write counter for RAW hazard stalling.
// Optional macro REGFILE_BYPASS_EN: same-cycle write-to-read forwarding of
// data and busy state.
module regfile_scoreboard #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] WriteReg,
  input  logic [DATA_W-1:0] WriteData,
  input  logic [ADDR_W-1:0] ReadReg1,
  input  logic [ADDR_W-1:0] ReadReg2,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2,
  input  logic              IssueEn,
  input  logic [ADDR_W-1:0] IssueReg,
  output logic              Busy1,
  output logic              Busy2,
  output logic [ADDR_W:0]   PendingCnt
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic              wrValid, issValid, cntInc, cntDec;

  // Register 0 is neither writable nor trackable when hardwired to zero.
  assign wrValid  = RegWrite && !(ZERO_REG && WriteReg == '0);
  assign issValid = IssueEn  && !(ZERO_REG && IssueReg == '0);
  // A same-cycle issue to the written register keeps it busy: no decrement.
  assign cntInc   = issValid && !busy[IssueReg];
  assign cntDec   = wrValid && busy[WriteReg] && !(issValid && IssueReg == WriteReg);

  // Storage: synchronous reset clears every entry, then writeback.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (wrValid) begin
      regs[WriteReg] <= WriteData;
    end
  end

  // Scoreboard: writeback clears, issue sets afterward so the new producer wins.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy       <= '0;
      PendingCnt <= '0;
    end else begin
      if (wrValid)  busy[WriteReg] <= 1'b0;
      if (issValid) busy[IssueReg] <= 1'b1;
      PendingCnt <= PendingCnt + (ADDR_W+1)'(cntInc) - (ADDR_W+1)'(cntDec);
    end
  end

  function automatic logic [DATA_W-1:0] rdData(input logic [ADDR_W-1:0] a);
    if (ZERO_REG && a == '0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (wrValid && WriteReg == a) return WriteData;
`endif
    return regs[a];
  endfunction

  function automatic logic rdBusy(input logic [ADDR_W-1:0] a);
    if (ZERO_REG && a == '0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
    if (wrValid && WriteReg == a) return issValid && IssueReg == a;
`endif
    return busy[a];
  endfunction

  // Combinational read ports.
  always_comb begin
    ReadData1 = rdData(ReadReg1);
    ReadData2 = rdData(ReadReg2);
    Busy1     = rdBusy(ReadReg1);
    Busy2     = rdBusy(ReadReg2);
  end
endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard: directed test-plan cases plus random traffic checked
// against an array model of registers and busy flags (count = popcount).
module tb_regfile_scoreboard;
  logic        clk = 1'b0;
  logic        rst_n, RegWrite, IssueEn, Busy1, Busy2;
  logic [4:0]  WriteReg, ReadReg1, ReadReg2, IssueReg;
  logic [31:0] WriteData, ReadData1, ReadData2;
  logic [5:0]  PendingCnt;

  int nTests = 0, nFail = 0;

  logic [31:0] mMem  [32];
  bit          mBusy [32];

  regfile_scoreboard #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .RegWrite(RegWrite), .WriteReg(WriteReg),
    .WriteData(WriteData), .ReadReg1(ReadReg1), .ReadReg2(ReadReg2),
    .ReadData1(ReadData1), .ReadData2(ReadData2), .IssueEn(IssueEn),
    .IssueReg(IssueReg), .Busy1(Busy1), .Busy2(Busy2), .PendingCnt(PendingCnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nTests++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit wrOk();
    return rst_n && RegWrite && WriteReg != 5'd0;
  endfunction

  function automatic bit issOk();
    return rst_n && IssueEn && IssueReg != 5'd0;
  endfunction

  function automatic logic [31:0] expData(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
`ifdef REGFILE_BYPASS_EN
    if (wrOk() && WriteReg == a) return WriteData;
`endif
    return mMem[a];
  endfunction

  function automatic logic expBusy(input logic [4:0] a);
    if (a == 5'd0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
    if (wrOk() && WriteReg == a) return issOk() && IssueReg == a;
`endif
    return mBusy[a];
  endfunction

  function automatic int pending();
    int n = 0;
    for (int i = 0; i < 32; i++) n += int'(mBusy[i]);
    return n;
  endfunction

  // Apply inputs, let them settle, compare all outputs against the model.
  task automatic setIn(input bit rst, input bit rw, input logic [4:0] wr,
                       input logic [31:0] wd, input bit ie, input logic [4:0] ir,
                       input logic [4:0] r1, input logic [4:0] r2);
    rst_n = rst; RegWrite = rw; WriteReg = wr; WriteData = wd;
    IssueEn = ie; IssueReg = ir; ReadReg1 = r1; ReadReg2 = r2;
    #2;
    chk("rd1",  {32'd0, ReadData1}, {32'd0, expData(r1)});
    chk("rd2",  {32'd0, ReadData2}, {32'd0, expData(r2)});
    chk("bsy1", 64'(Busy1), 64'(expBusy(r1)));
    chk("bsy2", 64'(Busy2), 64'(expBusy(r2)));
    chk("pend", 64'(PendingCnt), 64'(pending()));
  endtask

  // Clock edge: update the model from the held inputs.
  task automatic tick();
    @(posedge clk);
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin mMem[i] = 32'd0; mBusy[i] = 1'b0; end
    end else begin
      if (wrOk()) begin mMem[WriteReg] = WriteData; mBusy[WriteReg] = 1'b0; end
      if (issOk()) mBusy[IssueReg] = 1'b1;
    end
    #1;
  endtask

  task automatic cyc(input bit rst, input bit rw, input logic [4:0] wr,
                     input logic [31:0] wd, input bit ie, input logic [4:0] ir,
                     input logic [4:0] r1, input logic [4:0] r2);
    setIn(rst, rw, wr, wd, ie, ir, r1, r2);
    tick();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin mMem[i] = 32'd0; mBusy[i] = 1'b0; end
    rst_n = 1'b0; RegWrite = 1'b0; WriteReg = '0; WriteData = '0;
    IssueEn = 1'b0; IssueReg = '0; ReadReg1 = '0; ReadReg2 = '0;
    @(posedge clk); #1;
    // 1: reset with a write held to r5; it must be dropped.
    rst_n = 1'b0; RegWrite = 1'b1; WriteReg = 5'd5; WriteData = 32'hDEAD_BEEF;
    tick();
    for (int a = 0; a < 32; a += 2) cyc(1, 0, 0, 0, 0, 0, 5'(a), 5'(a + 1));
    setIn(1, 0, 0, 0, 0, 0, 5'd5, 5'd5);
    chk("t1_r5", {32'd0, ReadData1}, 64'd0);
    chk("t1_pend", 64'(PendingCnt), 64'd0);
    tick();
    // 2: hardwired zero register.
    cyc(1, 1, 5'd0,  32'h1234_5678, 0, 0, 0, 0);
    cyc(1, 1, 5'd31, 32'h1234_5678, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 1, 5'd0, 5'd0, 5'd31);
    setIn(1, 0, 0, 0, 0, 0, 5'd0, 5'd31);
    chk("t2_r0", {32'd0, ReadData1}, 64'd0);
    chk("t2_r31", {32'd0, ReadData2}, 64'h1234_5678);
    chk("t2_b0", 64'(Busy1), 64'd0);
    chk("t2_pend", 64'(PendingCnt), 64'd0);
    tick();
    // 3: issue r3, r4, r3 then writebacks.
    cyc(1, 0, 0, 0, 1, 5'd3, 5'd3, 5'd4);
    setIn(1, 0, 0, 0, 1, 5'd4, 5'd3, 5'd4);
    chk("t3_p1", 64'(PendingCnt), 64'd1);
    tick();
    setIn(1, 0, 0, 0, 1, 5'd3, 5'd3, 5'd4);
    chk("t3_p2", 64'(PendingCnt), 64'd2);
    tick();
    setIn(1, 1, 5'd3, 32'h33, 0, 0, 5'd3, 5'd4);
    chk("t3_p2b", 64'(PendingCnt), 64'd2);
    chk("t3_b3", 64'(Busy1), 64'd1);
    tick();
    setIn(1, 1, 5'd7, 32'h77, 0, 0, 5'd3, 5'd7);
    chk("t3_b3clr", 64'(Busy1), 64'd0);
    chk("t3_p1b", 64'(PendingCnt), 64'd1);
    tick();
    setIn(1, 0, 0, 0, 0, 0, 5'd7, 5'd4);
    chk("t3_p1c", 64'(PendingCnt), 64'd1);
    tick();
    // 4: issue and write r9 in one cycle while r9 is busy.
    cyc(1, 0, 0, 0, 1, 5'd9, 5'd9, 5'd9);
    cyc(1, 1, 5'd9, 32'hA5A5_A5A5, 1, 5'd9, 5'd9, 5'd1);
    setIn(1, 0, 0, 0, 0, 0, 5'd9, 5'd1);
    chk("t4_r9", {32'd0, ReadData1}, 64'hA5A5_A5A5);
    chk("t4_b9", 64'(Busy1), 64'd1);
    chk("t4_pend", 64'(PendingCnt), 64'd2);
    tick();
    // 5: read-during-write on r2.
    cyc(1, 1, 5'd2, 32'h11, 0, 0, 0, 0);
    setIn(1, 1, 5'd2, 32'h22, 0, 0, 5'd2, 5'd0);
`ifdef REGFILE_BYPASS_EN
    chk("t5_rdw", {32'd0, ReadData1}, 64'h22);
`else
    chk("t5_rdw", {32'd0, ReadData1}, 64'h11);
`endif
    tick();
    setIn(1, 0, 0, 0, 0, 0, 5'd2, 5'd0);
    chk("t5_next", {32'd0, ReadData1}, 64'h22);
    tick();
    // 6: issue r1..r31, reset mid-stream.
    for (int a = 1; a < 32; a++) begin
      if (a == 20) cyc(0, 1, 5'(a), 32'hFFFF, 1, 5'(a), 5'(a - 1), 5'd3);
      else cyc(1, 1, 5'(a), 32'(a * 3), 1, 5'(a), 5'(a - 1), 5'd3);
    end
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    for (int a = 0; a < 32; a += 2) cyc(1, 0, 0, 0, 0, 0, 5'(a), 5'(a + 1));
    setIn(1, 0, 0, 0, 0, 0, 5'd25, 5'd31);
    chk("t6_pend", 64'(PendingCnt), 64'd0);
    chk("t6_r31", {32'd0, ReadData2}, 64'd0);
    tick();
    // Random traffic; narrow address range some of the time to force collisions.
    for (int n = 0; n < 600; n++) begin
      automatic logic [4:0] hi = ($urandom_range(0, 1) != 0) ? 5'd31 : 5'd3;
      cyc($urandom_range(0, 63) != 0, $urandom_range(0, 1) != 0,
          5'($urandom_range(0, hi)), $urandom, $urandom_range(0, 1) != 0,
          5'($urandom_range(0, hi)), 5'($urandom_range(0, hi)),
          5'($urandom_range(0, hi)));
    end
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end
endmodule
